// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Shares one single-port RAM (fixed 1-cycle read latency) between two
// requesters: requester 0 is the serial BIOS loader and requester 1 is the
// CPU memory interface. A round-robin choice is made in ARB. The chosen
// command is driven onto the RAM port in ISSUE. For reads, the RAM data is
// returned to the owner in RESP.
//
// Optional feature: define RAM_ARB_STATS_EN to enable the per-requester
// 16-bit saturating grant counters. When it is undefined, both counters
// read 0 and have no flops.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_cpu_en            requester 1 may only be arbitrated while this is 1
//   i_req/i_we          per-requester request and write flag
//   i_be*/i_addr*/i_wdata*  per-requester command fields
//   o_gnt               one-cycle pulse, command accepted (ISSUE)
//   o_rvalid/o_rdata    one-cycle read-data pulse (RESP); o_rdata holds
//                       its value between pulses
//   o_ram_*             RAM command port; fields are 0 when o_ram_en is 0
//   i_ram_rdata         RAM read data, one cycle after a read command
//   o_busy              sequencer is not in ARB
//   o_gnt_cnt0/1        grant counters
//   o_dbg_state         current sequencer state (ARB=0, ISSUE=1, RESP=2)
//
// Handshake: a requester raises i_req[n] and holds its fields stable until
// o_gnt[n] pulses. In the gnt cycle it either drops i_req[n] or presents a
// new command. Dropping i_req[n] before the gnt cancels the command.
// i_req[n] still high after a gnt counts as a new request.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cpu_en,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_we,
  input  logic [3:0]            i_be0,
  input  logic [3:0]            i_be1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic [1:0]            o_gnt,
  output logic [1:0]            o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [3:0]            o_ram_be,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_busy,
  output logic [15:0]           o_gnt_cnt0,
  output logic [15:0]           o_gnt_cnt1,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic elig0, elig1;
  logic owner_req, owner_we;
  logic issue_go, resp_go;

  assign elig0 = i_req[0];
  assign elig1 = i_req[1] & i_cpu_en;

  // Only i_req is rechecked in ISSUE, not i_cpu_en. A CPU command that
  // already won arbitration completes even if the enable falls.
  assign owner_req = owner_q ? i_req[1] : i_req[0];
  assign owner_we  = owner_q ? i_we[1]  : i_we[0];

  // rst gates the command and response strobes in the same cycle, so an
  // aborted transaction never shows a gnt, RAM command or rvalid.
  assign issue_go = (state_q == ST_ISSUE) && owner_req && !rst;
  assign resp_go  = (state_q == ST_RESP) && !rst;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_ARB: begin
        if (elig0 || elig1) begin
          state_d = ST_ISSUE;
          // On a tie, the requester not served last wins.
          owner_d = (elig0 && elig1) ? ~last_q : elig1;
        end
      end
      ST_ISSUE: begin
        if (owner_req) begin
          last_d  = owner_q;
          state_d = owner_we ? ST_ARB : ST_RESP;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_RESP: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (state_q == ST_RESP) rdata_q <= i_ram_rdata;
    end
  end

  assign o_ram_en    = issue_go;
  assign o_ram_we    = issue_go & owner_we;
  assign o_ram_be    = !issue_go ? 4'b0 : (owner_q ? i_be1 : i_be0);
  assign o_ram_addr  = !issue_go ? '0 : (owner_q ? i_addr1 : i_addr0);
  assign o_ram_wdata = !issue_go ? '0 : (owner_q ? i_wdata1 : i_wdata0);

  assign o_gnt    = !issue_go ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign o_rvalid = !resp_go  ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign o_rdata  = resp_go ? i_ram_rdata : rdata_q;

  assign o_busy      = (state_q != ST_ARB);
  assign o_dbg_state = state_q;

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (o_gnt[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (o_gnt[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign o_gnt_cnt0 = cnt0_q;
  assign o_gnt_cnt1 = cnt1_q;
`else
  assign o_gnt_cnt0 = 16'd0;
  assign o_gnt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter.
// Directed steps from the test plan run first, then a randomized phase.
// A transaction-level reference model runs every cycle. It predicts
// grants, RAM commands, read responses and counters from timestamps and a
// shadow memory. A simple behavioural RAM answers the DUT's RAM port.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  be_r[2];
  logic [31:0] addr_r[2];
  logic [31:0] wdata_r[2];

  logic [1:0]  o_gnt, o_rvalid, o_dbg_state;
  logic [31:0] o_rdata, o_ram_addr, o_ram_wdata;
  logic        o_ram_en, o_ram_we, o_busy;
  logic [3:0]  o_ram_be;
  logic [15:0] o_gnt_cnt0, o_gnt_cnt1;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst), .i_cpu_en(cpu_en), .i_req(req), .i_we(we),
    .i_be0(be_r[0]), .i_be1(be_r[1]), .i_addr0(addr_r[0]), .i_addr1(addr_r[1]),
    .i_wdata0(wdata_r[0]), .i_wdata1(wdata_r[1]),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_be(o_ram_be),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .o_busy(o_busy), .o_gnt_cnt0(o_gnt_cnt0), .o_gnt_cnt1(o_gnt_cnt1),
    .o_dbg_state(o_dbg_state)
  );

  // Behavioural RAM: byte-enabled writes, registered read one cycle later.
  logic [31:0] ram_mem[int];
  always @(posedge clk) begin
    if (o_ram_en) begin
      if (o_ram_we) begin
        logic [31:0] w;
        w = ram_mem.exists(int'(o_ram_addr[5:0])) ? ram_mem[int'(o_ram_addr[5:0])] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (o_ram_be[b]) w[8*b +: 8] = o_ram_wdata[8*b +: 8];
        ram_mem[int'(o_ram_addr[5:0])] = w;
      end else begin
        ram_rdata <= ram_mem.exists(int'(o_ram_addr[5:0])) ? ram_mem[int'(o_ram_addr[5:0])] : 32'h0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow[int];
  int          cyc;
  int          m_owner, m_last, m_issue_at, m_resp_at;
  logic [31:0] m_rdata, m_hold;
  logic [15:0] m_cnt0, m_cnt1;
  logic [1:0]  m_eg;          // grants predicted for the last cycle
  logic [1:0]  s_gnt, s_rv;   // DUT strobes sampled in the last cycle
  logic        s_en;

  task automatic model_reset();
    m_issue_at = -1;
    m_resp_at  = -1;
    m_owner    = 0;
    m_last     = 1;
    m_hold     = 32'h0;
    m_cnt0     = 16'h0;
    m_cnt1     = 16'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_and_check();
    logic [1:0]  eg, ev;
    logic        ee, ew, e_busy, e0, e1;
    logic [3:0]  eb;
    logic [31:0] ea, ed, erd, w;
    logic [15:0] c0, c1;
    int          idx;
    eg = 2'b00; ev = 2'b00; ee = 1'b0; ew = 1'b0;
    eb = 4'h0; ea = 32'h0; ed = 32'h0;
    e_busy = (cyc == m_issue_at) || (cyc == m_resp_at);
    erd = m_hold;
    c0 = m_cnt0;
    c1 = m_cnt1;
    if (!rst) begin
      if (cyc == m_issue_at) begin
        if (req[m_owner]) begin
          eg[m_owner] = 1'b1;
          ee = 1'b1;
          ew = we[m_owner];
          eb = be_r[m_owner];
          ea = addr_r[m_owner];
          ed = wdata_r[m_owner];
          m_last = m_owner;
          idx = int'(ea[5:0]);
          w = shadow.exists(idx) ? shadow[idx] : 32'h0;
          if (ew) begin
            for (int b = 0; b < 4; b++)
              if (eb[b]) w[8*b +: 8] = ed[8*b +: 8];
            shadow[idx] = w;
          end else begin
            m_resp_at = cyc + 1;
            m_rdata = w;
          end
        end
      end else if (cyc == m_resp_at) begin
        ev[m_owner] = 1'b1;
        erd = m_rdata;
        m_hold = m_rdata;
      end else begin
        e0 = req[0];
        e1 = req[1] & cpu_en;
        if (e0 || e1) begin
          m_owner = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
          m_issue_at = cyc + 1;
        end
      end
      if (eg[0] && m_cnt0 != 16'hFFFF) m_cnt0++;
      if (eg[1] && m_cnt1 != 16'hFFFF) m_cnt1++;
    end
`ifndef RAM_ARB_STATS_EN
    c0 = 16'h0;
    c1 = 16'h0;
`endif
    chk("gnt", {30'h0, o_gnt}, {30'h0, eg});
    chk("rvalid", {30'h0, o_rvalid}, {30'h0, ev});
    chk("ram_en", {31'h0, o_ram_en}, {31'h0, ee});
    chk("ram_we", {31'h0, o_ram_we}, {31'h0, ew});
    chk("ram_be", {28'h0, o_ram_be}, {28'h0, eb});
    chk("ram_addr", o_ram_addr, ea);
    chk("ram_wdata", o_ram_wdata, ed);
    chk("rdata", o_rdata, erd);
    chk("busy", {31'h0, o_busy}, {31'h0, e_busy});
    chk("dbg_idle", {31'h0, (o_dbg_state == 2'd0)}, {31'h0, !e_busy});
    chk("gnt_cnt0", {16'h0, o_gnt_cnt0}, {16'h0, c0});
    chk("gnt_cnt1", {16'h0, o_gnt_cnt1}, {16'h0, c1});
    m_eg  = eg;
    s_gnt = o_gnt;
    s_rv  = o_rvalid;
    s_en  = o_ram_en;
    if (rst) model_reset();
    cyc++;
  endtask

  // One clock cycle: check at the falling edge, then return just after
  // the next rising edge so that new inputs can be driven.
  task automatic tick();
    @(negedge clk);
    model_and_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    we[r] = w;
    addr_r[r] = a;
    wdata_r[r] = d;
    be_r[r] = b;
    req[r] = 1'b1;
  endtask

  // Ticks until the DUT grants requester r. n is the number of cycles
  // before the grant cycle, or -1 if no grant came within the budget.
  task automatic wait_gnt(input int r, output int n);
    logic found;
    found = 1'b0;
    n = -1;
    for (int k = 0; k < 12; k++) begin
      if (!found) begin
        tick();
        if (s_gnt[r]) begin
          found = 1'b1;
          n = k;
        end
      end
    end
  endtask

  task automatic drive_random();
    for (int r = 0; r < 2; r++) begin
      if (m_eg[r] || !req[r]) begin
        if ($urandom_range(0, 99) < 60)
          set_cmd(r, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                  4'($urandom_range(1, 15)));
        else
          req[r] = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        req[r] = 1'b0;
      end
    end
    if ($urandom_range(0, 99) < 5) cpu_en = ~cpu_en;
  endtask

  initial begin
    int n, cnt_g, rv0, rv1, gi;
    int order[4];
    cyc = 0;
    model_reset();
    m_eg = 2'b00;
    rst = 1'b1;
    cpu_en = 1'b0;
    req = 2'b00;
    we = 2'b00;
    for (int r = 0; r < 2; r++) begin
      be_r[r] = 4'h0; addr_r[r] = 32'h0; wdata_r[r] = 32'h0;
    end
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // BIOS write with the CPU disabled.
    set_cmd(0, 1'b1, 32'h10, 32'hA5, 4'b0001);
    wait_gnt(0, n);
    chk("bios_wr_gnt_latency", n, 1);
    req[0] = 1'b0;
    tick();
    chk("bios_wr_busy_after", {31'h0, o_busy}, 32'h0);
    chk("bios_wr_no_rvalid", {30'h0, s_rv}, 32'h0);

    // BIOS read of the same word.
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'b1111);
    wait_gnt(0, n);
    chk("bios_rd_gnt_latency", n, 1);
    req[0] = 1'b0;
    tick();
    chk("bios_rd_rvalid", {30'h0, s_rv}, 32'h1);
    chk("bios_rd_rdata", o_rdata, 32'h000000A5);

    // CPU held off while i_cpu_en is low.
    set_cmd(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    cnt_g = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (s_gnt[1] || s_en) cnt_g++;
    end
    chk("cpu_gated_no_cmd", cnt_g, 0);
    cpu_en = 1'b1;
    wait_gnt(1, n);
    chk("cpu_enabled_gnt_latency", n, 1);
    req[1] = 1'b0;
    tick();

    // Round-robin: both requesters hold reads continuously.
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'b1111);
    set_cmd(1, 1'b0, 32'h20, 32'h0, 4'b1111);
    gi = 0; rv0 = 0; rv1 = 0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    for (int k = 0; k < 20; k++) begin
      if (gi < 4) begin
        tick();
        rv0 += int'(s_rv[0]);
        rv1 += int'(s_rv[1]);
        if (s_gnt != 2'b00) begin
          order[gi] = s_gnt[1] ? 1 : 0;
          gi++;
        end
      end
    end
    req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      rv0 += int'(s_rv[0]);
      rv1 += int'(s_rv[1]);
    end
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    chk("rr_rvalid0", rv0, 2);
    chk("rr_rvalid1", rv1, 2);

    // Cancel: req0 drops while its command sits in ISSUE.
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'b1111);
    tick();
    req[0] = 1'b0;
    tick();
    chk("cancel_no_gnt", {30'h0, s_gnt}, 32'h0);
    chk("cancel_no_ram_en", {31'h0, s_en}, 32'h0);
    chk("cancel_back_to_arb", {31'h0, o_busy}, 32'h0);
    set_cmd(0, 1'b0, 32'h10, 32'h0, 4'b1111);
    set_cmd(1, 1'b0, 32'h20, 32'h0, 4'b1111);
    tick();
    tick();
    chk("cancel_next_tie", {30'h0, s_gnt}, 32'h1);
    req = 2'b00;
    tick();
    tick();

    // Reset during RESP.
    set_cmd(1, 1'b0, 32'h20, 32'h0, 4'b1111);
    wait_gnt(1, n);
    req[1] = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_resp_no_rvalid", {30'h0, s_rv}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_rdata_zero", o_rdata, 32'h0);
    chk("rst_busy_zero", {31'h0, o_busy}, 32'h0);
    chk("rst_outputs_zero", {28'h0, o_gnt, o_rvalid}, 32'h0);

    // Grant statistics: three grants to requester 0, two to requester 1.
    for (int k = 0; k < 5; k++) begin
      set_cmd(k < 3 ? 0 : 1, 1'b1, 32'(k), 32'h1000 + 32'(k), 4'b1111);
      wait_gnt(k < 3 ? 0 : 1, n);
      req = 2'b00;
    end
    tick();
`ifdef RAM_ARB_STATS_EN
    chk("stats_cnt0", {16'h0, o_gnt_cnt0}, 32'd3);
    chk("stats_cnt1", {16'h0, o_gnt_cnt1}, 32'd2);
`else
    chk("stats_cnt0", {16'h0, o_gnt_cnt0}, 32'd0);
    chk("stats_cnt1", {16'h0, o_gnt_cnt1}, 32'd0);
`endif

    // Randomized traffic, including cancels, enable toggles and resets.
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    req = 2'b00;
    for (int k = 0; k < 4; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port program/data RAM between two requesters: requester 0 is the serial BIOS loader and requester 1 is the CPU memory interface. The arbiter uses round-robin arbitration and a three-phase sequencer (ARB → ISSUE → RESP) that drives one RAM command at a time and routes read data back to its owner. A CPU-enable input gates requester 1 so that only the BIOS can reach RAM before boot.

Parameters:
ADDR_WIDTH, 32, address width of requesters and RAM
DATA_WIDTH, 32, data width of requesters and RAM
- The RAM has a fixed 1-cycle read latency; this is not parameterised.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_cpu_en  input  1  1 = requester 1 eligible for arbitration (driven by BIOS boot flag)
i_req[1:0]  input  2  per-requester request; held until gnt
i_we[1:0]  input  2  per-requester write (1) / read (0)
i_be0, i_be1  input  4 each  byte enables
i_addr0, i_addr1  input  ADDR_WIDTH each  address
i_wdata0, i_wdata1  input  DATA_WIDTH each  write data
o_gnt[1:0]  output  2  one-cycle pulse; command accepted this cycle
o_rvalid[1:0]  output  2  one-cycle pulse; read data valid
o_rdata  output  DATA_WIDTH  read data, shared, qualified by o_rvalid
o_ram_en  output  1  RAM command strobe
o_ram_we  output  1  RAM write
o_ram_be  output  4  RAM byte enables
o_ram_addr  output  ADDR_WIDTH  RAM address
o_ram_wdata  output  DATA_WIDTH  RAM write data
i_ram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after a read command
o_busy  output  1  state != ARB
o_gnt_cnt0, o_gnt_cnt1  output  16 each  grant counters (see Optional Feature)

Behaviour:
- Reset values:
  - state = ARB, owner = 0, last = 1, so requester 0 wins the first tie.
  - All outputs are 0: gnt, rvalid, ram_en, ram_we, ram_be, ram_addr, ram_wdata, rdata, busy, counters.
- Eligibility:
  - elig0 = i_req[0].
  - elig1 = i_req[1] & i_cpu_en.
- ARB state:
  - If neither requester is eligible, stay in ARB.
  - If exactly one is eligible, it becomes owner.
  - If both are eligible, owner = ~last.
  - Owner is registered on the transition to ISSUE.
- ISSUE state (1 cycle):
  - If i_req[owner] is still 1:
    - The RAM port is driven combinationally from the owner's we/be/addr/wdata, with o_ram_en = 1.
    - o_gnt[owner] = 1.
    - last <= owner.
    - Reads go to RESP; writes go to ARB.
  - If i_req[owner] has dropped, the command is cancelled:
    - No ram_en and no gnt.
    - last is unchanged.
    - Return to ARB.
- RESP state (1 cycle, reads only):
  - o_rvalid[owner] = 1.
  - o_rdata = i_ram_rdata.
  - Return to ARB.
- o_rdata holds its last value when o_rvalid is 0.
- o_ram_be, o_ram_addr and o_ram_wdata are 0 when o_ram_en = 0.
- Latency from req assertion (arbiter idle):
  - gnt at +1 cycle.
  - rvalid at +2 cycles.
  - Next arbitration: +2 cycles after a write, +3 cycles after a read.
- Requester protocol:
  - Fields must stay stable while req = 1.
  - After a gnt, the requester deasserts req or presents a new command in the same cycle.
  - A req still high in the cycle after gnt is treated as a new request.
- i_cpu_en falling while requester 1 is in ISSUE or RESP: the in-flight transaction completes; requester 1 is excluded from the next ARB onward.
- rst asserted mid-transaction: aborts immediately to the reset state; no rvalid is produced for the aborted read.
- Exactly one of o_gnt bits may be high in any cycle; the same holds for o_rvalid.

Optional Feature:
Macro: RAM_ARB_STATS_EN
- Defined:
  - o_gnt_cnt0 and o_gnt_cnt1 increment on each o_gnt pulse of the matching requester.
  - Counters are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: both counters are tied to 0 and no counter flops exist.

Test Plan:
- BIOS write, i_cpu_en=0: req0 write with addr 0x10, wdata 0xA5, be 4'b0001. Expect gnt0 at +1 cycle with ram_en=1, ram_we=1, ram_addr=0x10, ram_wdata=0xA5; no rvalid; busy low at +2.
- BIOS read: req0 read at addr 0x10, ram_rdata=0x000000A5 in the following cycle. Expect gnt0 at +1 and rvalid0 at +2 with rdata=0x000000A5.
- CPU gated: i_cpu_en=0 and req1 held for 10 cycles → no gnt1 and no ram_en. Set i_cpu_en=1 → gnt1 in the following ISSUE cycle.
- Round-robin: both requesters assert reads continuously with i_cpu_en=1. Expect the grant order 0,1,0,1 with one rvalid per grant, each to the matching owner.
- Cancel and reset:
  - req0 drops during ISSUE → no ram_en, no gnt0, state back to ARB, and next tie goes to requester 0.
  - rst during RESP → no rvalid, all outputs 0 the next cycle.
- Stats (macro defined): 3 grants to requester 0 and 2 to requester 1 → o_gnt_cnt0=3, o_gnt_cnt1=2. With the macro undefined, both read 0.
